// File: rtl/nn_train_scheduler.sv
// Sample FIFO, start/done sequencer and periodic progress reporter for NN training.
// Define NN_SCHED_WATCHDOG_EN to bound WAIT with a WDOG_CYCLES watchdog.
module nn_train_scheduler #(
    parameter int NPIXEL       = 784,
    parameter int CNT_BITS     = 14,
    parameter int REPORT_EVERY = 100,
    parameter int WDOG_CYCLES  = 1048576
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_valid,
    input  logic [NPIXEL-1:0]   rx_pixel,
    input  logic [3:0]          rx_label,
    output logic                rx_ready,
    output logic                nn_start,
    output logic [NPIXEL-1:0]   nn_pixel,
    output logic [3:0]          nn_label,
    input  logic                nn_done,
    input  logic                nn_correct,
    output logic [CNT_BITS-1:0] yes_cnt,
    output logic [CNT_BITS-1:0] no_cnt,
    output logic                rpt_valid,
    output logic [7:0]          rpt_byte,
    input  logic                rpt_ready,
    output logic                busy,
    output logic                ovf,
    output logic                wdog_err
);

    if (REPORT_EVERY < 1 || REPORT_EVERY > 255 || WDOG_CYCLES < 1) begin : g_param_chk
        $error("nn_train_scheduler: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, START, WAIT, REPORT} state_t;

    state_t              state_q, state_d;
    logic [NPIXEL-1:0]   fifo_pix_q [2];
    logic [NPIXEL-1:0]   fifo_pix_d [2];
    logic [3:0]          fifo_lbl_q [2];
    logic [3:0]          fifo_lbl_d [2];
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [NPIXEL-1:0]   nn_pixel_q, nn_pixel_d;
    logic [3:0]          nn_label_q, nn_label_d;
    logic                nn_start_q, nn_start_d;
    logic [CNT_BITS-1:0] yes_q, yes_d;
    logic [CNT_BITS-1:0] no_q, no_d;
    logic [7:0]          smp_q, smp_d;
    logic [2:0]          rpt_idx_q, rpt_idx_d;
    logic                rpt_valid_q, rpt_valid_d;
    logic [7:0]          rpt_byte_q, rpt_byte_d;
    logic [13:0]         snap_yes_q, snap_yes_d;
    logic [13:0]         snap_no_q, snap_no_d;
    logic                busy_q, busy_d;
    logic                ovf_q, ovf_d;
    logic                rx_ready_q, rx_ready_d;
    logic                push, pop, push_slot, timeout;

    always_comb begin
        state_d     = state_q;
        fifo_pix_d  = fifo_pix_q;
        fifo_lbl_d  = fifo_lbl_q;
        nn_pixel_d  = nn_pixel_q;
        nn_label_d  = nn_label_q;
        nn_start_d  = 1'b0;
        yes_d       = yes_q;
        no_d        = no_q;
        smp_d       = smp_q;
        rpt_idx_d   = rpt_idx_q;
        rpt_valid_d = rpt_valid_q;
        rpt_byte_d  = rpt_byte_q;
        snap_yes_d  = snap_yes_q;
        snap_no_d   = snap_no_q;
        pop         = 1'b0;
        push        = rx_valid & rx_ready_q;
        ovf_d       = ovf_q | (rx_valid & ~rx_ready_q);

        unique case (state_q)
            IDLE: begin
                if (fifo_cnt_q != 2'd0) begin
                    pop        = 1'b1;
                    nn_pixel_d = fifo_pix_q[0];
                    nn_label_d = fifo_lbl_q[0];
                    nn_start_d = 1'b1;
                    state_d    = START;
                end
            end
            START: state_d = WAIT;
            WAIT: begin
                if (nn_done || timeout) begin
                    if (nn_done && nn_correct) begin
                        if (yes_q != '1) yes_d = yes_q + 1'b1;
                    end else if (no_q != '1) begin
                        no_d = no_q + 1'b1;
                    end
                    smp_d = smp_q + 8'd1;
                    if (smp_d == 8'(REPORT_EVERY)) begin
                        state_d     = REPORT;
                        rpt_valid_d = 1'b1;
                        rpt_byte_d  = 8'hA5;
                        rpt_idx_d   = 3'd0;
                        snap_yes_d  = 14'(yes_d);
                        snap_no_d   = 14'(no_d);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            REPORT: begin
                if (rpt_ready) begin
                    if (rpt_idx_q == 3'd4) begin
                        state_d     = IDLE;
                        rpt_valid_d = 1'b0;
                        rpt_byte_d  = 8'h00;
                        smp_d       = 8'd0;
                    end else begin
                        rpt_idx_d = rpt_idx_q + 3'd1;
                        case (rpt_idx_d)
                            3'd1:    rpt_byte_d = {2'b00, snap_yes_q[13:8]};
                            3'd2:    rpt_byte_d = snap_yes_q[7:0];
                            3'd3:    rpt_byte_d = {2'b00, snap_no_q[13:8]};
                            default: rpt_byte_d = snap_no_q[7:0];
                        endcase
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Head is always slot 0; a push lands just behind whatever survives the pop.
        push_slot = pop ? fifo_cnt_q[1] : fifo_cnt_q[0];
        if (pop) begin
            fifo_pix_d[0] = fifo_pix_q[1];
            fifo_lbl_d[0] = fifo_lbl_q[1];
        end
        if (push) begin
            fifo_pix_d[push_slot] = rx_pixel;
            fifo_lbl_d[push_slot] = rx_label;
        end
        fifo_cnt_d = fifo_cnt_q - {1'b0, pop} + {1'b0, push};
        rx_ready_d = (fifo_cnt_d != 2'd2);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            fifo_pix_q  <= '{default: '0};
            fifo_lbl_q  <= '{default: '0};
            fifo_cnt_q  <= 2'd0;
            nn_pixel_q  <= '0;
            nn_label_q  <= 4'd0;
            nn_start_q  <= 1'b0;
            yes_q       <= '0;
            no_q        <= '0;
            smp_q       <= 8'd0;
            rpt_idx_q   <= 3'd0;
            rpt_valid_q <= 1'b0;
            rpt_byte_q  <= 8'h00;
            snap_yes_q  <= 14'd0;
            snap_no_q   <= 14'd0;
            busy_q      <= 1'b0;
            ovf_q       <= 1'b0;
            rx_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            fifo_pix_q  <= fifo_pix_d;
            fifo_lbl_q  <= fifo_lbl_d;
            fifo_cnt_q  <= fifo_cnt_d;
            nn_pixel_q  <= nn_pixel_d;
            nn_label_q  <= nn_label_d;
            nn_start_q  <= nn_start_d;
            yes_q       <= yes_d;
            no_q        <= no_d;
            smp_q       <= smp_d;
            rpt_idx_q   <= rpt_idx_d;
            rpt_valid_q <= rpt_valid_d;
            rpt_byte_q  <= rpt_byte_d;
            snap_yes_q  <= snap_yes_d;
            snap_no_q   <= snap_no_d;
            busy_q      <= busy_d;
            ovf_q       <= ovf_d;
            rx_ready_q  <= rx_ready_d;
        end
    end

`ifdef NN_SCHED_WATCHDOG_EN
    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;
    logic              wdog_err_q, wdog_err_d;

    always_comb begin
        wdog_cnt_d = '0;
        wdog_err_d = wdog_err_q;
        timeout    = 1'b0;
        if (state_q == WAIT && !nn_done) begin
            if (wdog_cnt_q == WDOG_W'(WDOG_CYCLES - 1)) begin
                timeout    = 1'b1;
                wdog_err_d = 1'b1;
            end else begin
                wdog_cnt_d = wdog_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

    assign wdog_err = wdog_err_q;
`else
    assign timeout  = 1'b0;
    assign wdog_err = 1'b0;
`endif

    assign rx_ready  = rx_ready_q;
    assign nn_start  = nn_start_q;
    assign nn_pixel  = nn_pixel_q;
    assign nn_label  = nn_label_q;
    assign yes_cnt   = yes_q;
    assign no_cnt    = no_q;
    assign rpt_valid = rpt_valid_q;
    assign rpt_byte  = rpt_byte_q;
    assign busy      = busy_q;
    assign ovf       = ovf_q;

endmodule
